// File: rtl/usb_ctrl_pkg.sv
// Shared request codes, FSM state encoding and SETUP packet layout for EP0 class decoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package usb_ctrl_pkg;

    localparam logic [7:0] REQ_MSD_RESET   = 8'hFF;
    localparam logic [7:0] REQ_GET_MAX_LUN = 8'hFE;
    localparam logic [7:0] REQ_SET_LC      = 8'h20;
    localparam logic [7:0] REQ_GET_LC      = 8'h21;
    localparam logic [7:0] REQ_SET_CLS     = 8'h22;

    localparam logic [7:0] RT_CLASS_OUT    = 8'h21;
    localparam logic [7:0] RT_CLASS_IN     = 8'hA1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP_RX,
        ST_DECODE,
        ST_RSP_TX,
        ST_DATA_RX
    } state_t;

    typedef struct packed {
        logic [7:0]  bm_req_type;
        logic [7:0]  b_request;
        logic [15:0] w_value;
        logic [15:0] w_index;
        logic [15:0] w_length;
    } setup_pkt_t;

    // Line coding is 7 bytes; a host may ask for more or fewer.
    function automatic logic [2:0] min_len7(input logic [15:0] len);
        return (len > 16'd7) ? 3'd7 : len[2:0];
    endfunction

endpackage

// File: rtl/usb_setup_capture.sv
// Captures the 8 SETUP bytes by index; pkt_vld_o strobes when setup_i falls after all 8 arrived.
// Latency: bytes land one edge after rxval_i; pkt_vld_o is combinational on the setup_i fall.
// Backpressure: none; bytes past the 8th are dropped, the index saturates.
module usb_setup_capture (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        en_i,
    input  logic        setup_i,
    input  logic        rxval_i,
    input  logic [7:0]  rxdat_i,
    output logic [63:0] pkt_o,
    output logic        pkt_vld_o
);

    logic [7:0] byte_q [8];
    logic [2:0] cnt_q;
    logic       full_q;
    logic [2:0] idx;
    logic       take;

    // A start cycle restarts at index 0 so a byte arriving with the setup rise is not lost.
    always_comb begin
        idx  = start_i ? 3'd0 : cnt_q;
        take = (start_i | en_i) & setup_i & rxval_i & (start_i | ~full_q);
    end

    // Byte store and saturating index; full_q marks that byte 7 has been written.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= 3'd0;
            full_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                byte_q[i] <= 8'h00;
            end
        end else begin
            if (start_i) begin
                cnt_q  <= 3'd0;
                full_q <= 1'b0;
            end
            if (take) begin
                byte_q[idx] <= rxdat_i;
                if (idx == 3'd7) begin
                    full_q <= 1'b1;
                end else begin
                    cnt_q <= idx + 3'd1;
                end
            end
        end
    end

    assign pkt_o     = {byte_q[0], byte_q[1], byte_q[3], byte_q[2],
                        byte_q[5], byte_q[4], byte_q[7], byte_q[6]};
    assign pkt_vld_o = en_i & ~setup_i & full_q;

endmodule

// File: rtl/usb_class_req_decoder.sv
// Decodes MSD Bulk-Only and CDC-ACM class SETUP requests on EP0; drives responses, strobes, line state.
// Latency: strobes and first response push appear the cycle after DECODE (2 cycles after setup_i falls).
// Backpressure: rsp_tx_full_i stalls the response indefinitely without loss; a new SETUP aborts it.
module usb_class_req_decoder
    import usb_ctrl_pkg::*;
#(
    parameter logic [7:0]  MSD_IFACE    = 8'd0,
    parameter logic [7:0]  CDC_IFACE    = 8'd1,
    parameter logic [7:0]  MAX_LUN      = 8'd0,
    parameter logic [31:0] DEFAULT_BAUD = 32'd115200
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        setup_i,
    input  logic        rxval_i,
    input  logic [7:0]  rxdat_i,
    output logic [7:0]  rsp_tx_dat_o,
    output logic        rsp_tx_ena_o,
    input  logic        rsp_tx_full_i,
    output logic        msd_rst_req_o,
    output logic        msd_get_max_lun_o,
    output logic        rsp_tx_err_o,
    output logic [55:0] cdc_line_coding_o,
    output logic        cdc_dtr_o,
    output logic        cdc_rts_o
);

    localparam logic [55:0] LC_RESET = {8'd8, 8'd0, 8'd0, DEFAULT_BAUD};

    state_t      state_q, state_d;
    logic [63:0] pkt_flat;
    setup_pkt_t  pkt;
    logic        pkt_vld, cap_start, cap_en;
    logic [55:0] rsp_sr_q, lc_q;
    logic [47:0] lc_shadow_q;
    logic [2:0]  rsp_cnt_q, data_cnt_q;
    logic        dtr_q, rts_q, rst_pulse_q, lun_pulse_q, err_pulse_q;
    logic        is_msd_rst, is_get_lun, is_get_lc, is_set_lc, is_set_cls;
    logic        push, data_take;
    logic        unused_bits;

    assign pkt         = setup_pkt_t'(pkt_flat);
    assign unused_bits = ^{pkt.w_value[15:2], pkt.w_index[15:8]};
    assign cap_start   = setup_i & ((state_q == ST_IDLE) | (state_q == ST_RSP_TX) | (state_q == ST_DATA_RX));
    assign cap_en      = (state_q == ST_SETUP_RX);

    usb_setup_capture u_cap (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (cap_start),
        .en_i      (cap_en),
        .setup_i   (setup_i),
        .rxval_i   (rxval_i),
        .rxdat_i   (rxdat_i),
        .pkt_o     (pkt_flat),
        .pkt_vld_o (pkt_vld)
    );

    // Request classification and per-cycle push/capture qualifiers.
    always_comb begin
        is_msd_rst = (pkt.bm_req_type == RT_CLASS_OUT) && (pkt.b_request == REQ_MSD_RESET)
                     && (pkt.w_index[7:0] == MSD_IFACE) && (pkt.w_length == 16'd0);
        is_get_lun = (pkt.bm_req_type == RT_CLASS_IN) && (pkt.b_request == REQ_GET_MAX_LUN)
                     && (pkt.w_index[7:0] == MSD_IFACE);
        is_get_lc  = (pkt.bm_req_type == RT_CLASS_IN) && (pkt.b_request == REQ_GET_LC)
                     && (pkt.w_index[7:0] == CDC_IFACE);
        is_set_lc  = (pkt.bm_req_type == RT_CLASS_OUT) && (pkt.b_request == REQ_SET_LC)
                     && (pkt.w_index[7:0] == CDC_IFACE);
        is_set_cls = (pkt.bm_req_type == RT_CLASS_OUT) && (pkt.b_request == REQ_SET_CLS)
                     && (pkt.w_index[7:0] == CDC_IFACE);
        // A new SETUP only lets the final byte through; earlier bytes are abandoned.
        push       = (state_q == ST_RSP_TX) && !rsp_tx_full_i && (!setup_i || (rsp_cnt_q == 3'd1));
        data_take  = (state_q == ST_DATA_RX) && rxval_i && !setup_i;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (setup_i) state_d = ST_SETUP_RX;
            ST_SETUP_RX: if (!setup_i) state_d = pkt_vld ? ST_DECODE : ST_IDLE;
            ST_DECODE: begin
                state_d = ST_IDLE;
                if (is_get_lun || (is_get_lc && (pkt.w_length != 16'd0))) state_d = ST_RSP_TX;
                else if (is_set_lc) state_d = ST_DATA_RX;
            end
            ST_RSP_TX: begin
                if (setup_i) state_d = ST_SETUP_RX;
                else if (push && (rsp_cnt_q == 3'd1)) state_d = ST_IDLE;
            end
            ST_DATA_RX: begin
                if (setup_i) state_d = ST_SETUP_RX;
                else if (data_take && (data_cnt_q == 3'd6)) state_d = ST_IDLE;
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Response shifter, strobes, CDC line state and staged line-coding commit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_sr_q    <= '0;
            rsp_cnt_q   <= 3'd0;
            data_cnt_q  <= 3'd0;
            lc_shadow_q <= '0;
            lc_q        <= LC_RESET;
            dtr_q       <= 1'b0;
            rts_q       <= 1'b0;
            rst_pulse_q <= 1'b0;
            lun_pulse_q <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            rst_pulse_q <= 1'b0;
            lun_pulse_q <= 1'b0;
            err_pulse_q <= (state_q == ST_RSP_TX) && setup_i && !push;
            if (state_q == ST_DECODE) begin
                rst_pulse_q <= is_msd_rst;
                lun_pulse_q <= is_get_lun;
                data_cnt_q  <= 3'd0;
                if (is_get_lun) begin
                    rsp_sr_q  <= {48'd0, MAX_LUN};
                    rsp_cnt_q <= 3'd1;
                end else if (is_get_lc) begin
                    // Snapshot now so a later SET commit cannot alter bytes in flight.
                    rsp_sr_q  <= lc_q;
                    rsp_cnt_q <= min_len7(pkt.w_length);
                end
                if (is_set_cls) begin
                    dtr_q <= pkt.w_value[0];
                    rts_q <= pkt.w_value[1];
                end
            end
            if (push) begin
                rsp_sr_q <= {8'h00, rsp_sr_q[55:8]};
                if (rsp_cnt_q != 3'd0) rsp_cnt_q <= rsp_cnt_q - 3'd1;
            end
            if (data_take) begin
                if (data_cnt_q == 3'd6) begin
                    lc_q <= {rxdat_i, lc_shadow_q};
                end else begin
                    lc_shadow_q <= {rxdat_i, lc_shadow_q[47:8]};
                    data_cnt_q  <= data_cnt_q + 3'd1;
                end
            end
        end
    end

    assign rsp_tx_ena_o      = push;
    assign rsp_tx_dat_o      = push ? rsp_sr_q[7:0] : 8'h00;
    assign msd_rst_req_o     = rst_pulse_q;
    assign msd_get_max_lun_o = lun_pulse_q;
    assign rsp_tx_err_o      = err_pulse_q;
    assign cdc_line_coding_o = lc_q;
    assign cdc_dtr_o         = dtr_q;
    assign cdc_rts_o         = rts_q;

endmodule

// File: tb/tb_usb_class_req_decoder.sv
// Randomized and directed bench for usb_class_req_decoder against a transaction-level model.
// Latency: n/a.
// Backpressure: drives rsp_tx_full_i randomly or as a fixed stall window.
module tb_usb_class_req_decoder;

    localparam logic [55:0] LC_DEF = {8'd8, 8'd0, 8'd0, 32'd115200};

    logic        clk_i = 1'b0;
    logic        rst_i, setup_i, rxval_i, rsp_tx_full_i;
    logic [7:0]  rxdat_i, rsp_tx_dat_o;
    logic        rsp_tx_ena_o, msd_rst_req_o, msd_get_max_lun_o, rsp_tx_err_o;
    logic [55:0] cdc_line_coding_o;
    logic        cdc_dtr_o, cdc_rts_o;

    always #5 clk_i = ~clk_i;

    usb_class_req_decoder dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .setup_i           (setup_i),
        .rxval_i           (rxval_i),
        .rxdat_i           (rxdat_i),
        .rsp_tx_dat_o      (rsp_tx_dat_o),
        .rsp_tx_ena_o      (rsp_tx_ena_o),
        .rsp_tx_full_i     (rsp_tx_full_i),
        .msd_rst_req_o     (msd_rst_req_o),
        .msd_get_max_lun_o (msd_get_max_lun_o),
        .rsp_tx_err_o      (rsp_tx_err_o),
        .cdc_line_coding_o (cdc_line_coding_o),
        .cdc_dtr_o         (cdc_dtr_o),
        .cdc_rts_o         (cdc_rts_o)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] obs_q[$];
    int n_rst = 0, n_lun = 0, n_err = 0, n_viol = 0;

    logic [7:0]  exp_q[$];
    int          e_rst, e_lun, e_err;
    logic [55:0] e_lc;
    logic        e_dtr, e_rts;
    int          base_push, base_rst, base_lun, base_err, base_viol;

    int bp_mode    = 0;
    int stall_left = 0;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (rsp_tx_ena_o) begin
            obs_q.push_back(rsp_tx_dat_o);
            if (rsp_tx_full_i) n_viol++;
        end
        if (msd_rst_req_o)     n_rst++;
        if (msd_get_max_lun_o) n_lun++;
        if (rsp_tx_err_o)      n_err++;
    end

    // FIFO-full driver: off, random, or a stall window opened after the 2nd push.
    initial begin
        rsp_tx_full_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            case (bp_mode)
                1: rsp_tx_full_i = ($urandom_range(0, 1) == 1);
                2: begin
                    if ((obs_q.size() - base_push) >= 2 && stall_left > 0) begin
                        rsp_tx_full_i = 1'b1;
                        stall_left--;
                    end else begin
                        rsp_tx_full_i = 1'b0;
                    end
                end
                default: rsp_tx_full_i = 1'b0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [63:0] mk(input logic [7:0] bm, input logic [7:0] br,
                                       input logic [15:0] wv, input logic [15:0] wi,
                                       input logic [15:0] wl);
        return {wl, wi, wv, br, bm};
    endfunction

    task automatic send_setup(input logic [63:0] p, input int n);
        step();
        setup_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            rxval_i = 1'b1;
            rxdat_i = (i < 8) ? p[8*i +: 8] : 8'($urandom);
        end
        step();
        rxval_i = 1'b0;
        setup_i = 1'b0;
    endtask

    task automatic send_data(input logic [55:0] d, input int n);
        step();
        for (int i = 0; i < n; i++) begin
            step();
            rxval_i = 1'b1;
            rxdat_i = d[8*i +: 8];
        end
        step();
        rxval_i = 1'b0;
    endtask

    // Reference: what a complete SETUP should produce, from the request tables.
    task automatic model_setup(input logic [63:0] p, input int n, output bit want_data);
        logic [7:0]  bm, br;
        logic [15:0] wv, wi, wl;
        bm = p[7:0];   br = p[15:8];  wv = p[31:16];
        wi = p[47:32]; wl = p[63:48];
        want_data = 1'b0;
        if (n < 8) return;
        if (bm == 8'h21 && br == 8'hFF && wi[7:0] == 8'd0 && wl == 16'd0) begin
            e_rst++;
        end else if (bm == 8'hA1 && br == 8'hFE && wi[7:0] == 8'd0) begin
            e_lun++;
            exp_q.push_back(8'h00);
        end else if (bm == 8'hA1 && br == 8'h21 && wi[7:0] == 8'd1) begin
            for (int i = 0; i < 7 && i < int'(wl); i++) exp_q.push_back(e_lc[8*i +: 8]);
        end else if (bm == 8'h21 && br == 8'h20 && wi[7:0] == 8'd1) begin
            want_data = 1'b1;
        end else if (bm == 8'h21 && br == 8'h22 && wi[7:0] == 8'd1) begin
            e_dtr = wv[0];
            e_rts = wv[1];
        end
    endtask

    task automatic txn_begin();
        base_push = obs_q.size();
        base_rst  = n_rst;
        base_lun  = n_lun;
        base_err  = n_err;
        base_viol = n_viol;
        exp_q.delete();
        e_rst = 0; e_lun = 0; e_err = 0;
    endtask

    task automatic txn_end(input string tag);
        int budget;
        logic [63:0] got;
        budget = 400;
        while ((obs_q.size() - base_push) < exp_q.size() && budget > 0) begin
            step();
            budget--;
        end
        check($sformatf("%s_timeout", tag), 64'(budget == 0), 64'd0);
        repeat (4) step();
        bp_mode = 0;
        check($sformatf("%s_npush", tag), 64'(obs_q.size() - base_push), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            got = (base_push + i < obs_q.size()) ? 64'(obs_q[base_push + i]) : 64'hFFFF;
            check($sformatf("%s_byte%0d", tag, i), got, 64'(exp_q[i]));
        end
        check($sformatf("%s_rstpulse", tag), 64'(n_rst - base_rst), 64'(e_rst));
        check($sformatf("%s_lunpulse", tag), 64'(n_lun - base_lun), 64'(e_lun));
        check($sformatf("%s_errpulse", tag), 64'(n_err - base_err), 64'(e_err));
        check($sformatf("%s_fullpush", tag), 64'(n_viol - base_viol), 64'd0);
        check($sformatf("%s_lc", tag), 64'(cdc_line_coding_o), 64'(e_lc));
        check($sformatf("%s_dtr", tag), 64'(cdc_dtr_o), 64'(e_dtr));
        check($sformatf("%s_rts", tag), 64'(cdc_rts_o), 64'(e_rts));
    endtask

    task automatic do_req(input string tag, input logic [63:0] p, input int n,
                          input logic [55:0] d, input int bp);
        bit wd;
        txn_begin();
        bp_mode = bp;
        send_setup(p, n);
        model_setup(p, n, wd);
        if (wd) begin
            send_data(d, 7);
            e_lc = d;
        end
        txn_end(tag);
    endtask

    initial begin
        bit          wd;
        logic [63:0] p;
        logic [55:0] d;
        logic [15:0] wi;
        int          kind, n;

        rst_i = 1'b1; setup_i = 1'b0; rxval_i = 1'b0; rxdat_i = 8'h00;
        e_lc = LC_DEF; e_dtr = 1'b0; e_rts = 1'b0;
        repeat (3) step();
        check("rst_ena", 64'(rsp_tx_ena_o), 64'd0);
        check("rst_dat", 64'(rsp_tx_dat_o), 64'd0);
        check("rst_pulses", 64'({msd_rst_req_o, msd_get_max_lun_o, rsp_tx_err_o}), 64'd0);
        check("rst_lc", 64'(cdc_line_coding_o), 64'(LC_DEF));
        check("rst_dtr_rts", 64'({cdc_dtr_o, cdc_rts_o}), 64'd0);
        rst_i = 1'b0;
        step();

        do_req("msd_reset", mk(8'h21, 8'hFF, 16'h0, 16'h0, 16'h0), 8, '0, 0);
        do_req("max_lun", mk(8'hA1, 8'hFE, 16'h0, 16'h0, 16'h1), 8, '0, 0);
        do_req("set_lc", mk(8'hA1 ^ 8'h80, 8'h20, 16'h0, 16'h1, 16'h7), 8,
               56'h08_00_00_0001C200, 0);
        do_req("get_lc", mk(8'hA1, 8'h21, 16'h0, 16'h1, 16'h7), 8, '0, 0);

        stall_left = 20;
        do_req("get_lc_stall", mk(8'hA1, 8'h21, 16'h0, 16'h1, 16'h7), 8, '0, 2);

        // Abort a stalled GET_LINE_CODING with a SET_CONTROL_LINE_STATE.
        txn_begin();
        stall_left = 100000;
        bp_mode = 2;
        send_setup(mk(8'hA1, 8'h21, 16'h0, 16'h1, 16'h7), 8);
        for (int b = 0; b < 200 && (obs_q.size() - base_push) < 2; b++) step();
        repeat (5) step();
        exp_q.push_back(e_lc[7:0]);
        exp_q.push_back(e_lc[15:8]);
        e_err = 1;
        send_setup(mk(8'h21, 8'h22, 16'h3, 16'h1, 16'h0), 8);
        model_setup(mk(8'h21, 8'h22, 16'h3, 16'h1, 16'h0), 8, wd);
        txn_end("abort_rsp");

        do_req("trunc", mk(8'h21, 8'h22, 16'h0, 16'h1, 16'h0), 5, '0, 0);

        // SET_LINE_CODING cut short by a new SETUP: no commit, no error.
        txn_begin();
        send_setup(mk(8'h21, 8'h20, 16'h0, 16'h1, 16'h7), 8);
        send_data(56'h07_02_01_00002580, 3);
        send_setup(mk(8'h21, 8'hFF, 16'h0, 16'h0, 16'h0), 8);
        model_setup(mk(8'h21, 8'hFF, 16'h0, 16'h0, 16'h0), 8, wd);
        txn_end("abort_data");

        // Reset in the middle of a SET_LINE_CODING data stage.
        txn_begin();
        send_setup(mk(8'h21, 8'h20, 16'h0, 16'h1, 16'h7), 8);
        send_data(56'h07_02_01_00002580, 3);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("midrst_ena", 64'(rsp_tx_ena_o), 64'd0);
        e_lc = LC_DEF; e_dtr = 1'b0; e_rts = 1'b0;
        txn_end("midrst");

        for (int it = 0; it < 150; it++) begin
            kind = $urandom_range(0, 6);
            wi   = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 3)) : 16'hFFFF;
            n    = ($urandom_range(0, 7) == 0) ? $urandom_range(9, 10) : 8;
            d    = {24'($urandom), 32'($urandom)};
            case (kind)
                0: p = mk(8'h21, 8'hFF, 16'($urandom), (wi == 16'hFFFF) ? 16'h0 : wi,
                          ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 9)) : 16'h0);
                1: p = mk(8'hA1, 8'hFE, 16'h0, (wi == 16'hFFFF) ? 16'h0 : wi, 16'h1);
                2: p = mk(8'hA1, 8'h21, 16'h0, (wi == 16'hFFFF) ? 16'h1 : wi,
                          16'($urandom_range(0, 12)));
                3: p = mk(8'h21, 8'h20, 16'h0, (wi == 16'hFFFF) ? 16'h1 : wi, 16'h7);
                4: p = mk(8'h21, 8'h22, 16'($urandom), (wi == 16'hFFFF) ? 16'h1 : wi, 16'h0);
                5: p = {$urandom, $urandom};
                default: begin
                    p = mk(8'h21, 8'h22, 16'($urandom), 16'h1, 16'h0);
                    n = $urandom_range(1, 7);
                end
            endcase
            do_req($sformatf("rnd%0d_k%0d", it, kind), p, n, d, $urandom_range(0, 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
